noc_demux_buffered: RTL

NOC_DEMUX_BUFFERED -- requirements
Module: noc_demux_buffered

---
 rtl/noc_demux_buffered.sv | 130 +++++++++++++
 1 files changed

// File: rtl/noc_demux_buffered.sv
// Packet demultiplexer: routes each packet by the class field of its header flit to one
// output channel, buffered by a per-channel FIFO. Optional macro: NOC_DEMUX_DROP_UNMAPPED_EN.
module noc_demux_buffered #(
    parameter int          FLIT_WIDTH = 32,
    parameter int          CHANNELS   = 3,
    parameter logic [63:0] MAPPING    = 64'h0,
    parameter int          CLASS_LSB  = 24,
    parameter int          DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FLIT_WIDTH-1:0]          in_flit,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]            out_valid,
    output logic [CHANNELS-1:0]            out_last,
    input  logic [CHANNELS-1:0]            out_ready
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t          state_reg, state_next;
    logic [CH_W-1:0] chan_reg, chan_next;

    logic [63:0]         mapping_vec;
    logic [2:0]          cls;
    logic [CHANNELS-1:0] mask;
    logic [CH_W-1:0]     dec_chan;
    logic [CH_W-1:0]     target;
    logic                drop_cycle;
    logic                in_fire;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] push;

    assign mapping_vec = MAPPING;
    assign cls         = in_flit[CLASS_LSB +: 3];
    assign mask        = mapping_vec[{cls, 3'b000} +: CHANNELS];

    // Lowest set bit wins; an all-zero mask falls back to channel 0.
    always_comb begin
        dec_chan = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (mask[c]) dec_chan = CH_W'(c);
        end
    end

`ifdef NOC_DEMUX_DROP_UNMAPPED_EN
    logic unmapped;
    assign unmapped   = (mask == '0);
    assign drop_cycle = (state_reg == DROP) || ((state_reg == IDLE) && unmapped);
`else
    assign drop_cycle = 1'b0;
`endif

    assign target   = (state_reg == FWD) ? chan_reg : dec_chan;
    assign in_ready = !rst && (drop_cycle || !full[target]);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            chan_reg  <= '0;
        end else begin
            state_reg <= state_next;
            chan_reg  <= chan_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        chan_next  = chan_reg;
        case (state_reg)
            IDLE: begin
                if (in_fire && !in_last) begin
                    if (drop_cycle) begin
                        state_next = DROP;
                    end else begin
                        state_next = FWD;
                        chan_next  = dec_chan;
                    end
                end
            end
            FWD, DROP: begin
                if (in_fire && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [FLIT_WIDTH:0] mem [DEPTH];
            logic [PTR_W-1:0]    wr_ptr_reg;
            logic [PTR_W-1:0]    rd_ptr_reg;
            logic [CNT_W-1:0]    count_reg;
            logic                pop;

            assign push[gi] = in_fire && !drop_cycle && (target == CH_W'(gi));
            assign pop      = out_valid[gi] && out_ready[gi];
            assign full[gi] = (count_reg == CNT_W'(DEPTH));

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (push[gi] && !pop)      count_reg <= count_reg + 1'b1;
                    else if (!push[gi] && pop) count_reg <= count_reg - 1'b1;
                end
            end

            // Storage is left unreset so it can map onto distributed RAM.
            always_ff @(posedge clk) begin
                if (push[gi]) mem[wr_ptr_reg] <= {in_last, in_flit};
            end

            assign out_valid[gi] = !rst && (count_reg != '0);
            assign {out_last[gi], out_flit[gi*FLIT_WIDTH +: FLIT_WIDTH]} = mem[rd_ptr_reg];
        end
    endgenerate
endmodule
